// File: rtl/lecture_keypad.sv
// 4x4 matrix-keypad reader: column scan, 2-FF row synchronizer, optional debouncer, key latch.
// Define LECTURE_DEBOUNCE_EN to enable the debouncer; otherwise rows go straight from the synchronizer.
module lecture_keypad #(
  parameter int unsigned CLK_HZ      = 27_000_000,
  parameter int unsigned SCAN_CYCLES = 54_000,
  parameter int unsigned DEB_CYCLES  = 13_500
) (
  input  logic       clk,
  input  logic       n_reset,
  input  logic [3:0] filas_raw,
  output logic [3:0] sample
);

  localparam int unsigned MaxCycles = (SCAN_CYCLES > DEB_CYCLES) ? SCAN_CYCLES : DEB_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles) + 1;
  localparam logic [CntW-1:0] ScanLast = CntW'(SCAN_CYCLES - 1);

  if (CLK_HZ == 0 || SCAN_CYCLES < 2 || DEB_CYCLES < 2) begin : g_bad_params
    $error("lecture_keypad: CLK_HZ must be nonzero, SCAN_CYCLES and DEB_CYCLES at least 2");
  end

  logic [3:0]      sync1_q, sync2_q;
  logic [3:0]      deb_rows, deb_rows_nxt;
  logic [3:0]      deb_prev_q;
  logic [3:0]      col_q, col_d;
  logic [CntW-1:0] scan_cnt_q, scan_cnt_d;
  logic [3:0]      sample_q, sample_d;
  logic            scan_adv;
  logic            accept;

  // Lowest row index wins; row0 is bit3.
  function automatic logic [3:0] key_code(input logic [3:0] rows, input logic [3:0] col);
    logic [1:0] r;
    logic [1:0] c;
    logic [3:0] code;
    if (rows[3])      r = 2'd0;
    else if (rows[2]) r = 2'd1;
    else if (rows[1]) r = 2'd2;
    else              r = 2'd3;
    unique case (col)
      4'b1000: c = 2'd0;
      4'b0100: c = 2'd1;
      4'b0010: c = 2'd2;
      4'b0001: c = 2'd3;
      default: c = 2'd0;
    endcase
    case ({r, c})
      4'd0:    code = 4'h1;
      4'd1:    code = 4'h2;
      4'd2:    code = 4'h3;
      4'd3:    code = 4'hA;
      4'd4:    code = 4'h4;
      4'd5:    code = 4'h5;
      4'd6:    code = 4'h6;
      4'd7:    code = 4'hB;
      4'd8:    code = 4'h7;
      4'd9:    code = 4'h8;
      4'd10:   code = 4'h9;
      4'd11:   code = 4'hC;
      4'd12:   code = 4'hE;
      4'd13:   code = 4'h0;
      4'd14:   code = 4'hF;
      default: code = 4'hD;
    endcase
    return code;
  endfunction

  always_ff @(posedge clk) begin
    if (n_reset) begin
      sync1_q <= 4'h0;
      sync2_q <= 4'h0;
    end else begin
      sync1_q <= filas_raw;
      sync2_q <= sync1_q;
    end
  end

`ifdef LECTURE_DEBOUNCE_EN
  localparam logic [CntW-1:0] DebLast = CntW'(DEB_CYCLES - 1);

  logic [3:0]      cand_q, cand_d;
  logic [3:0]      deb_q, deb_d;
  logic [CntW-1:0] deb_cnt_q, deb_cnt_d;

  // deb_d must not depend on scan_adv, which itself looks at deb_d.
  always_comb begin
    deb_d = deb_q;
    if (sync2_q == cand_q && deb_cnt_q == DebLast) begin
      deb_d = cand_q;
    end
  end

  always_comb begin
    cand_d    = cand_q;
    deb_cnt_d = deb_cnt_q;
    if (scan_adv) begin
      cand_d    = sync2_q;
      deb_cnt_d = '0;
    end else if (sync2_q != cand_q) begin
      // The changed sample itself counts as the first of the stable run.
      cand_d    = sync2_q;
      deb_cnt_d = CntW'(1);
    end else if (deb_cnt_q != DebLast) begin
      deb_cnt_d = deb_cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (n_reset) begin
      cand_q    <= 4'h0;
      deb_q     <= 4'h0;
      deb_cnt_q <= '0;
    end else begin
      cand_q    <= cand_d;
      deb_q     <= deb_d;
      deb_cnt_q <= deb_cnt_d;
    end
  end

  assign deb_rows     = deb_q;
  assign deb_rows_nxt = deb_d;
`else
  assign deb_rows     = sync2_q;
  assign deb_rows_nxt = sync1_q;
`endif

  // Scan also holds when rows are about to go nonzero so the accepted key keeps its column.
  always_comb begin
    scan_adv   = (deb_rows == 4'h0) && (deb_rows_nxt == 4'h0) && (scan_cnt_q == ScanLast);
    col_d      = col_q;
    scan_cnt_d = scan_cnt_q + CntW'(1);
    if (deb_rows != 4'h0 || deb_rows_nxt != 4'h0) begin
      scan_cnt_d = '0;
    end else if (scan_adv) begin
      scan_cnt_d = '0;
      col_d      = {col_q[0], col_q[3:1]};
    end
  end

  always_comb begin
    accept   = (deb_rows != 4'h0) && (deb_prev_q == 4'h0);
    sample_d = accept ? key_code(deb_rows, col_q) : sample_q;
  end

  always_ff @(posedge clk) begin
    if (n_reset) begin
      col_q      <= 4'b1000;
      scan_cnt_q <= '0;
      deb_prev_q <= 4'h0;
      sample_q   <= 4'h0;
    end else begin
      col_q      <= col_d;
      scan_cnt_q <= scan_cnt_d;
      deb_prev_q <= deb_rows;
      sample_q   <= sample_d;
    end
  end

  assign sample = sample_q;

endmodule

// File: tb/tb_lecture_keypad.sv
// Directed bench for lecture_keypad; expected key codes flow through a scoreboard queue.
module tb_lecture_keypad;

`ifdef LECTURE_DEBOUNCE_EN
  localparam int Lat = 11;
`else
  localparam int Lat = 3;
`endif

  logic       clk = 1'b0;
  logic       n_reset;
  logic [3:0] filas_raw;
  logic [3:0] sample;

  int errors = 0;
  int checks = 0;
  logic [3:0] exp_q[$];
  logic [3:0] codes[16] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                            4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD};

  lecture_keypad #(
    .CLK_HZ      (27_000_000),
    .SCAN_CYCLES (40),
    .DEB_CYCLES  (8)
  ) dut (
    .clk       (clk),
    .n_reset   (n_reset),
    .filas_raw (filas_raw),
    .sample    (sample)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic sb_check(input string tag);
    logic [3:0] exp;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: scoreboard empty, observed=%h", tag, sample);
    end else begin
      exp = exp_q.pop_front();
      check(tag, sample, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Waits for a fresh arrival of the target column, bounded.
  task automatic wait_col(input logic [3:0] target);
    int n = 0;
    while (dut.col_q == target && n < 400) begin
      @(negedge clk);
      n++;
    end
    while (dut.col_q != target && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) begin
      checks++;
      errors++;
      $error("FAIL wait_col: observed=%b expected=%b", dut.col_q, target);
    end
  endtask

  initial begin
    n_reset   = 1'b1;
    filas_raw = 4'h0;

    // 1. Reset state and first column advance.
    cycles(3);
    check("reset_sample", sample, 4'h0);
    check("reset_col", dut.col_q, 4'b1000);
    n_reset = 1'b0;
    cycles(39);
    check("col_before_adv", dut.col_q, 4'b1000);
    cycles(1);
    check("col_after_adv", dut.col_q, 4'b0100);

    // 2. Single press right after reset on column 1000.
    n_reset = 1'b1;
    cycles(3);
    n_reset   = 1'b0;
    filas_raw = 4'b1000;
    exp_q.push_back(4'h1);
    cycles(Lat - 1);
    check("press_early", sample, 4'h0);
    cycles(1);
    sb_check("press_accept");
    cycles(60);
    check("scan_frozen", dut.col_q, 4'b1000);
    filas_raw = 4'h0;
    cycles(20);
    check("release_holds", sample, 4'h1);

    // 3. Bouncing row1 on column 0100.
    wait_col(4'b0100);
    for (int i = 0; i < 5; i++) begin
      filas_raw = 4'b0100;
      cycles(3);
      filas_raw = 4'h0;
      cycles(3);
    end
`ifdef LECTURE_DEBOUNCE_EN
    exp_q.push_back(4'h1);
`else
    exp_q.push_back(4'h5);
`endif
    cycles(5);
    sb_check("bounce");
    cycles(15);

    // 4. Full key map.
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        logic [3:0] cb;
        cb = 4'b1000 >> c;
        wait_col(cb);
        filas_raw = 4'b1000 >> r;
        exp_q.push_back(codes[r*4 + c]);
        cycles(Lat);
        sb_check($sformatf("map_r%0d_c%0d", r, c));
        filas_raw = 4'h0;
        cycles(14);
      end
    end

    // 5. Two rows at once: row1 beats row2.
    wait_col(4'b0010);
    filas_raw = 4'b0110;
    exp_q.push_back(4'h6);
    cycles(Lat);
    sb_check("priority");
    filas_raw = 4'h0;
    cycles(14);

    // 6. Reset while a press is still in flight.
    wait_col(4'b0001);
    filas_raw = 4'b1000;
    cycles(2);
    n_reset = 1'b1;
    cycles(1);
    filas_raw = 4'h0;
    cycles(2);
    n_reset = 1'b0;
    check("midreset_sample", sample, 4'h0);
    check("midreset_col", dut.col_q, 4'b1000);
    cycles(60);
    check("midreset_no_accept", sample, 4'h0);
    wait_col(4'b0100);
    filas_raw = 4'b0010;
    exp_q.push_back(4'h8);
    cycles(Lat);
    sb_check("after_reset_press");
    filas_raw = 4'h0;
    cycles(5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
